// File: rtl/time_pkg.sv
// Shared time-of-day types and field limits for the digital clock and alarm path.
package time_pkg;

   typedef logic [6:0] tval_t;

   localparam int SEC_PER_MIN = 60;
   localparam int MIN_PER_HR  = 60;
   localparam int HR_PER_DAY  = 24;
   localparam int DAYS_PER_WK = 7;

   typedef enum logic {
      TK_RUN = 1'b0,
      TK_SET = 1'b1
   } tk_state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD field counter: synchronous load of rst_val, clear, and increment with wrap at MOD-1.
module mod_counter
   import time_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic  clk,
   input  logic  rst,
   input  tval_t rst_val,
   input  logic  clr,
   input  logic  inc,
   output tval_t q,
   output logic  wrap
);

   logic at_max;

   // Wrap on an explicit compare so no out-of-range value can ever be stored.
   assign at_max = (q == tval_t'(MOD - 1));
   assign wrap   = inc && at_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= rst_val;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= at_max ? '0 : q + tval_t'(1);
      end
   end

endmodule

// File: rtl/time_keeper.sv
// Seconds/minutes/hours/weekday chain with RUN (carrying) and SET (independent advance) modes.
// Optional seconds prescaler enabled by defining TK_PRESCALE_EN.
module time_keeper
   import time_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1,
   parameter int RESET_DAY     = 0
) (
   input  logic      Pulse,
   input  logic      Reset,
   input  logic      Timeset,
   input  logic      Minadv,
   input  logic      Hrsadv,
   input  logic      Dayadv,
   output tval_t     tsec,
   output tval_t     tmin,
   output tval_t     thrs,
   output tval_t     tdays,
   output logic      day_roll,
   output tk_state_e state
);

   if (TICKS_PER_SEC < 1) begin : g_bad_ticks
      $error("time_keeper: TICKS_PER_SEC must be >= 1");
   end

   tk_state_e state_next;
   logic      run;
   logic      tick;
   logic      sec_wrap;
   logic      min_wrap;
   logic      hr_wrap;
   logic      unused_day_wrap;
   logic      min_inc;
   logic      hr_inc;
   logic      day_inc;

   // Mode decisions use Timeset directly; the state register is a lagged mirror for observation.
   assign run = ~Timeset;

   always_ff @(posedge Pulse) begin
      if (Reset) begin
         state <= TK_RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (Timeset) begin
         state_next = TK_SET;
      end else begin
         state_next = TK_RUN;
      end
   end

`ifdef TK_PRESCALE_EN
   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

   logic [PW-1:0] pre;

   assign tick = run && (pre == PRE_MAX);

   always_ff @(posedge Pulse) begin
      if (Reset || Timeset || (pre == PRE_MAX)) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end
`else
   assign tick = run;
`endif

   // In SET each field takes its own button; in RUN each takes the carry from below.
   assign min_inc = Timeset ? Minadv : sec_wrap;
   assign hr_inc  = Timeset ? Hrsadv : min_wrap;
   assign day_inc = Timeset ? Dayadv : hr_wrap;

   mod_counter #(.MOD(SEC_PER_MIN)) u_sec (
      .clk(Pulse), .rst(Reset), .rst_val('0), .clr(Timeset), .inc(tick),
      .q(tsec), .wrap(sec_wrap)
   );

   mod_counter #(.MOD(MIN_PER_HR)) u_min (
      .clk(Pulse), .rst(Reset), .rst_val('0), .clr(1'b0), .inc(min_inc),
      .q(tmin), .wrap(min_wrap)
   );

   mod_counter #(.MOD(HR_PER_DAY)) u_hr (
      .clk(Pulse), .rst(Reset), .rst_val('0), .clr(1'b0), .inc(hr_inc),
      .q(thrs), .wrap(hr_wrap)
   );

   mod_counter #(.MOD(DAYS_PER_WK)) u_day (
      .clk(Pulse), .rst(Reset), .rst_val(tval_t'(RESET_DAY)), .clr(1'b0), .inc(day_inc),
      .q(tdays), .wrap(unused_day_wrap)
   );

   always_ff @(posedge Pulse) begin
      if (Reset) begin
         day_roll <= 1'b0;
      end else begin
         day_roll <= run && hr_wrap;
      end
   end

endmodule
